// File: rtl/fetch_stage_if.sv
// Fetch front-end bus: instruction-memory req/ack and datapath valid/ready.
// master = fetch stage side, slave = memory/datapath side.
interface fetch_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               im_req;
    logic [ADDR_W-1:0]  im_addr;
    logic               im_ack;
    logic [INSTR_W-1:0] im_rdata;
    logic               ins_valid;
    logic               ins_ready;
    logic [INSTR_W-1:0] ins;
    logic [ADDR_W-1:0]  ins_pc;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output im_req, im_addr, ins_valid, ins, ins_pc,
        input  im_ack, im_rdata, ins_ready, redirect, redirect_pc
    );

    modport slave (
        input  im_req, im_addr, ins_valid, ins, ins_pc,
        output im_ack, im_rdata, ins_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding memory request,
// small FIFO of {instr, pc} toward the datapath, redirect flush.
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]     ONE   = CW'(1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic [INSTR_W-1:0] dat_q [DEPTH];
    logic [ADDR_W-1:0]  tag_q [DEPTH];
    logic [PW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic              ack, pop, push, flush;
    logic [CW-1:0]     occ_pop;
    logic [ADDR_W-1:0] tgt, nxt;

    assign ack     = req_q & bus.im_ack;
    assign pop     = (cnt_q != '0) & bus.ins_ready;
    assign occ_pop = cnt_q - CW'(pop);
    assign tgt     = bus.redirect_pc & ALIGN;
    assign nxt     = addr_q + STEP;

    assign bus.im_req    = req_q;
    assign bus.im_addr   = addr_q;
    assign bus.ins_valid = (cnt_q != '0);
    assign bus.ins       = dat_q[rd_q];
    assign bus.ins_pc    = tag_q[rd_q];

    // Next-state: redirect wins over push/pop; request held until ack.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (bus.redirect) begin
            flush = 1'b1;
            pc_d  = tgt;
            unique case (state_q)
                IDLE: begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = tgt;
                end
                REQ, DISCARD: begin
                    if (ack) begin
                        state_d = REQ;
                        addr_d  = tgt;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (occ_pop < FULL) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                REQ: begin
                    if (ack) begin
                        push = 1'b1;
                        pc_d = nxt;
                        if (occ_pop + ONE < FULL) begin
                            addr_d = nxt;
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state_d = REQ;
                        addr_d  = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy: flush empties, otherwise push/pop may coincide.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control registers: FSM state, request, address, fetch PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    // FIFO pointers and count; flush rewinds both pointers.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // FIFO storage; cleared on reset so ins/ins_pc read zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (push) begin
            dat_q[wr_q] <= bus.im_rdata;
            tag_q[wr_q] <= addr_q;
        end
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end between Instruction_Memory and the Datapath instruction input.
- Owns the fetch PC and talks to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them with their PCs to the datapath over a valid/ready handshake.
- Accepts branch redirects that flush buffered and in-flight fetches.

Parameters:
- ADDR_W, 64, width of PC and instruction address.
- INSTR_W, 32, instruction width.
- DEPTH, 2, FIFO entries; power of 2, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-low.
- im_req  output  1  instruction-memory request, registered.
- im_addr  output  ADDR_W  request address, registered; bits [1:0] always 0.
- im_ack  input  1  memory returns im_rdata this cycle; ignored when im_req=0.
- im_rdata  input  INSTR_W  instruction data, valid when im_req&im_ack.
- ins_valid  output  1  FIFO head valid, registered.
- ins_ready  input  1  datapath accepts head.
- ins  output  INSTR_W  head instruction.
- ins_pc  output  ADDR_W  PC of head instruction.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch address; bits [1:0] forced to 0.

Behaviour:
- Reset (rst=0 at an edge):
  - im_req=0, im_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0.
  - FIFO empty; fetch_pc=RESET_PC; state=IDLE.
  - Reset overrides every other input in that cycle, including mid-request. A pending request is abandoned, and an im_ack in the reset cycle is ignored.
- States:
  - IDLE: no request outstanding.
  - REQ: im_req=1, waiting for ack.
  - DISCARD: redirect arrived while a request was outstanding; hold the request until ack and drop its data.
- Request rule:
  - Once im_req=1, im_req and im_addr stay constant until an edge with im_ack=1.
  - At most one request is outstanding.
- IDLE -> REQ:
  - Taken when occupancy after this edge's pop is < DEPTH.
  - Sets im_addr=fetch_pc and im_req=1 on that edge.
  - First request is visible the cycle after the first edge with rst=1.
- REQ with im_ack=1 and no redirect:
  - Write {im_rdata, im_addr} to the FIFO.
  - fetch_pc := im_addr+4, wrapping modulo 2^ADDR_W.
  - If post-write occupancy (counting a simultaneous pop) < DEPTH: stay in REQ with im_addr=im_addr+4. This gives back-to-back fetches with zero bubble.
  - Otherwise: go to IDLE, im_req=0.
- Output latency: an ack at edge N gives ins_valid=1 in the cycle after edge N if the FIFO was empty. There is no combinational path from im_ack to ins_valid.
- Pop:
  - ins_valid&ins_ready at an edge removes the head.
  - ins and ins_pc hold stable while ins_valid=1 and ins_ready=0.
- Simultaneous push and pop when full: legal. Occupancy is unchanged and ordering is preserved.
- Redirect (priority over push/pop):
  - FIFO is flushed at that edge; ins_valid=0 next cycle.
  - A head handshaken in the same cycle is void; the datapath discards it.
  - fetch_pc := {redirect_pc[ADDR_W-1:2],2'b00}.
  - Next state by current state:
    - IDLE: REQ at the new PC.
    - REQ with im_ack=1 this cycle: the returned data is dropped; go to REQ at the new PC.
    - REQ with im_ack=0: go to DISCARD; im_req and im_addr stay held.
- DISCARD:
  - On im_ack: drop data, go to REQ at the latched fetch_pc.
  - A further redirect in DISCARD updates fetch_pc only.
- PC wrap: im_addr=2^ADDR_W-4 is followed by im_addr=0; no error is raised.
- FIFO overflow is impossible by construction. Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

Test Plan:
- Reset then single-cycle memory (im_ack tied 1), ins_ready=1 -> im_addr sequence 0,4,8,12… with no gaps; ins_pc follows one cycle behind with matching ins.
- ins_ready=0, im_ack=1 -> exactly 2 instructions captured (PCs 0,4); im_req drops after second ack; ins/ins_pc hold 0. Raising ins_ready restarts requests at 8 one cycle later.
- Memory latency 3 cycles -> im_addr stable for 3 cycles per request; one instruction every 3 cycles; no duplicate or skipped PCs.
- Redirect to 0x1003 while a 3-cycle request to 0x8 is pending -> im_addr stays 0x8 until ack; that data is never presented; next im_addr=0x1000; first ins_pc after redirect=0x1000.
- Redirect with FIFO full and ins_ready=1 in the same cycle -> ins_valid=0 next cycle; the popped head is not re-presented; fetch resumes at the redirect target.
- rst=0 asserted mid-request at 0x20 with im_ack=1 the same cycle -> im_req=0, ins_valid=0 after the edge; after release, first im_addr=RESET_PC.
